pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Multicycle PC-update controller that owns the select and write strobes of the PC-source multiplexer. It accepts one PC-update request per instruction from the main control unit (sequential, branch, jump, register jump, exception return) and runs the full exception-entry sequence: save EPC, read the vector byte from memory into MDR, load PC from MDR. It sits between the main control FSM and the PC/EPC/MDR registers and replaces the ad-hoc PC strobes in the main FSM.

## Interface

- MEM_WAIT, 2: idle cycles between issuing the vector read and loading MDR (0..15).
- VEC_OPCODE, 8'd253: memory address of the invalid-opcode vector byte.
- VEC_OVF, 8'd254: memory address of the overflow vector byte.
- VEC_DIV0, 8'd255: memory address of the divide-by-zero vector byte.

- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  PC-update request present.
- req_kind  in  3  000 seq (RES), 001 branch (ALUOut), 010 jump target, 011 register target, 101 EPC return; others invalid.
- branch_taken  in  1  branch condition, sampled with the request.
- req_ready  out  1  request/exception accepted this cycle when high.
- exc_opcode, exc_ovf, exc_div0  in  1 each  exception levels, held until exc_ack.
- exc_ack  out  1  one-cycle pulse; exception latched.
- pc_source  out  3  PC mux select (000 RES, 001 ALUOut, 010 jump, 011 register, 100 MDR, 101 EPC).
- pc_write  out  1  PC load enable.
- epc_write  out  1  EPC load enable (datapath supplies PC-4).
- vec_addr  out  8  memory address during exception read; 0 otherwise.
- vec_read  out  1  memory read enable for vector fetch.
- mdr_write  out  1  MDR load enable.
- done  out  1  one-cycle pulse; update finished.

## Operation

- States: IDLE, ISSUE, EXC_SAVE, EXC_WAIT, EXC_LOAD, EXC_JUMP. All outputs Moore-decoded from state plus latched kind/taken/vector.
- req_ready = 1 only in IDLE with no exception input high.
- IDLE: any exception high -> latch vector, go EXC_SAVE (request not accepted, even if req_valid). Priority exc_opcode > exc_ovf > exc_div0. Else req_valid -> latch req_kind, branch_taken, go ISSUE.
- ISSUE: pc_source = latched kind; pc_write = 1 unless kind 001 with taken 0; done = 1; -> IDLE. Invalid kinds (100, 110, 111): pc_write 0, pc_source 000, done 1.
- EXC_SAVE: epc_write 1, exc_ack 1, vec_read 1, vec_addr = vector; -> EXC_WAIT (or EXC_LOAD if MEM_WAIT = 0).
- EXC_WAIT: vec_read 1, vec_addr held; 4-bit counter runs MEM_WAIT cycles; -> EXC_LOAD.
- EXC_LOAD: mdr_write 1, vec_addr held; -> EXC_JUMP.
- EXC_JUMP: pc_source 100, pc_write 1, done 1; -> IDLE.
- Exception inputs ignored outside IDLE; lower-priority exceptions still high after return are taken on the next IDLE cycle.
- Reset (any state): state IDLE, counter 0, latches 0; all outputs 0 except req_ready, which is 1 once out of reset. Reset mid-sequence aborts; no pc_write issued.

## Timing

- Request accepted at edge T (IDLE, req_valid, req_ready) -> pc_write/done in cycle T+1 -> req_ready again at T+2. Back-to-back requests: one per 2 cycles.
- Exception latched at edge T -> EXC_SAVE cycle T+1 -> EXC_WAIT T+2..T+1+MEM_WAIT -> EXC_LOAD T+2+MEM_WAIT -> EXC_JUMP (pc_write) T+3+MEM_WAIT. Default: pc_write at T+5.
- epc_write is exactly one cycle, before any pc_write of the sequence; PC unchanged until EXC_JUMP.
- pc_source is 000 in every state other than ISSUE and EXC_JUMP.

## Test plan

- Reset mid-EXC_WAIT: drop reset_n asynchronously -> all outputs 0 immediately, no pc_write; release -> req_ready 1.
- req_kind 001, branch_taken 0 -> next cycle pc_source 001, pc_write 0, done 1; repeat with taken 1 -> pc_write 1.
- Back-to-back jump (010) then EPC return (101) -> pc_write in cycles T+1 and T+3, pc_source 010 then 101, req_ready low in ISSUE.
- exc_ovf and exc_div0 raised together with req_valid -> request not accepted; vec_addr 254, epc_write once, pc_write with pc_source 100 five cycles after latch; exc_div0 still high -> second sequence with vec_addr 255.
- MEM_WAIT = 0 build, exc_opcode -> EXC_SAVE, EXC_LOAD, EXC_JUMP on consecutive cycles, vec_addr 253, pc_write at T+3.
- Invalid req_kind 111 -> done 1, pc_write 0, pc_source 000.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: multicycle PC-update controller.
// Owns the PC-source mux select and the PC/EPC/MDR write strobes. Accepts one
// PC-update request per instruction and runs the exception-entry sequence
// (save EPC, fetch vector byte into MDR, load PC from MDR).
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE with no exception
// input asserted, so a pending exception always wins over a pending request.
`timescale 1ns/1ps

module pc_sequencer #(
  parameter int         MEM_WAIT   = 2,
  parameter logic [7:0] VEC_OPCODE = 8'd253,
  parameter logic [7:0] VEC_OVF    = 8'd254,
  parameter logic [7:0] VEC_DIV0   = 8'd255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  input  logic [2:0] req_kind,
  input  logic       branch_taken,
  output logic       req_ready,
  input  logic       exc_opcode,
  input  logic       exc_ovf,
  input  logic       exc_div0,
  output logic       exc_ack,
  output logic [2:0] pc_source,
  output logic       pc_write,
  output logic       epc_write,
  output logic [7:0] vec_addr,
  output logic       vec_read,
  output logic       mdr_write,
  output logic       done,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_EXC_SAVE = 3'd2,
    S_EXC_WAIT = 3'd3,
    S_EXC_LOAD = 3'd4,
    S_EXC_JUMP = 3'd5
  } state_t;

  // Last value of the wait counter before moving on to EXC_LOAD.
  localparam logic [3:0] WAIT_LAST = (MEM_WAIT > 0) ? 4'(MEM_WAIT - 1) : 4'd0;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] wait_cnt;
  logic [2:0] kind_q;
  logic       taken_q;
  logic [7:0] vec_q;
  logic       exc_any;
  logic [7:0] vec_sel;
  logic       kind_valid;

  assign exc_any   = exc_opcode | exc_ovf | exc_div0;
  assign dbg_state = state;

  // Fixed exception priority: invalid opcode, then overflow, then divide-by-zero.
  always_comb begin
    vec_sel = VEC_DIV0;
    if (exc_opcode)   vec_sel = VEC_OPCODE;
    else if (exc_ovf) vec_sel = VEC_OVF;
  end

  // Kinds 100, 110 and 111 are not PC sources a request may select.
  always_comb begin
    kind_valid = (kind_q == 3'b000) || (kind_q == 3'b001) || (kind_q == 3'b010) ||
                 (kind_q == 3'b011) || (kind_q == 3'b101);
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Latch the request or the exception vector on the IDLE decision edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kind_q  <= 3'd0;
      taken_q <= 1'b0;
      vec_q   <= 8'd0;
    end else if (state == S_IDLE) begin
      if (exc_any) begin
        vec_q <= vec_sel;
      end else if (req_valid) begin
        kind_q  <= req_kind;
        taken_q <= branch_taken;
      end
    end
  end

  // Memory-wait counter: cleared in EXC_SAVE, counts through EXC_WAIT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  wait_cnt <= 4'd0;
    else if (state == S_EXC_SAVE)  wait_cnt <= 4'd0;
    else if (state == S_EXC_WAIT)  wait_cnt <= wait_cnt + 4'd1;
  end

  // Next-state logic; exception inputs are only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (exc_any)        state_nxt = S_EXC_SAVE;
        else if (req_valid) state_nxt = S_ISSUE;
      end
      S_ISSUE:    state_nxt = S_IDLE;
      S_EXC_SAVE: state_nxt = (MEM_WAIT == 0) ? S_EXC_LOAD : S_EXC_WAIT;
      S_EXC_WAIT: begin
        if (wait_cnt == WAIT_LAST) state_nxt = S_EXC_LOAD;
      end
      S_EXC_LOAD: state_nxt = S_EXC_JUMP;
      S_EXC_JUMP: state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Moore output decode from state plus latched kind/taken/vector.
  always_comb begin
    req_ready = 1'b0;
    exc_ack   = 1'b0;
    pc_source = 3'b000;
    pc_write  = 1'b0;
    epc_write = 1'b0;
    vec_addr  = 8'd0;
    vec_read  = 1'b0;
    mdr_write = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        // Held low while reset is asserted even though the state is IDLE.
        req_ready = reset_n && !exc_any;
      end
      S_ISSUE: begin
        done = 1'b1;
        if (kind_valid) begin
          pc_source = kind_q;
          pc_write  = !((kind_q == 3'b001) && !taken_q);
        end
      end
      S_EXC_SAVE: begin
        epc_write = 1'b1;
        exc_ack   = 1'b1;
        vec_read  = 1'b1;
        vec_addr  = vec_q;
      end
      S_EXC_WAIT: begin
        vec_read = 1'b1;
        vec_addr = vec_q;
      end
      S_EXC_LOAD: begin
        mdr_write = 1'b1;
        vec_addr  = vec_q;
      end
      S_EXC_JUMP: begin
        pc_source = 3'b100;
        pc_write  = 1'b1;
        done      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and random stimulus for pc_sequencer, checked
// against a timeline model: each accepted request or exception expands into
// the list of output cycles it must produce.
`timescale 1ns/1ps

module tb_pc_sequencer;

  localparam int MW = 2;
  localparam int OW = 18;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  // ---------------- DUT with default MEM_WAIT ----------------
  logic       req_valid, branch_taken, exc_opcode, exc_ovf, exc_div0;
  logic [2:0] req_kind;
  logic       req_ready, exc_ack, pc_write, epc_write, vec_read, mdr_write, done;
  logic [2:0] pc_source, dbg_state;
  logic [7:0] vec_addr;

  pc_sequencer #(.MEM_WAIT(MW)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_kind(req_kind),
    .branch_taken(branch_taken), .req_ready(req_ready), .exc_opcode(exc_opcode),
    .exc_ovf(exc_ovf), .exc_div0(exc_div0), .exc_ack(exc_ack), .pc_source(pc_source),
    .pc_write(pc_write), .epc_write(epc_write), .vec_addr(vec_addr), .vec_read(vec_read),
    .mdr_write(mdr_write), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- DUT with MEM_WAIT = 0 ----------------
  logic       req_valid0 = 1'b0, branch_taken0 = 1'b0, exc_ovf0 = 1'b0, exc_div0_0 = 1'b0;
  logic [2:0] req_kind0 = 3'd0;
  logic       exc_opcode0;
  logic       req_ready0, exc_ack0, pc_write0, epc_write0, vec_read0, mdr_write0, done0;
  logic [2:0] pc_source0, dbg_state0;
  logic [7:0] vec_addr0;

  pc_sequencer #(.MEM_WAIT(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid0), .req_kind(req_kind0),
    .branch_taken(branch_taken0), .req_ready(req_ready0), .exc_opcode(exc_opcode0),
    .exc_ovf(exc_ovf0), .exc_div0(exc_div0_0), .exc_ack(exc_ack0), .pc_source(pc_source0),
    .pc_write(pc_write0), .epc_write(epc_write0), .vec_addr(vec_addr0), .vec_read(vec_read0),
    .mdr_write(mdr_write0), .done(done0), .dbg_state(dbg_state0)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] exp0_q[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Layout: ready, ack, src[2:0], pc_write, epc_write, vaddr[7:0], vread, mdr_write, done
  function automatic logic [OW-1:0] pack(input logic rr, input logic ack, input logic [2:0] src,
                                         input logic pw, input logic ew, input logic [7:0] va,
                                         input logic vr, input logic mw, input logic dn);
    return {rr, ack, src, pw, ew, va, vr, mw, dn};
  endfunction

  // The single output cycle produced by an accepted PC-update request.
  function automatic logic [OW-1:0] issue_vec(input logic [2:0] k, input logic t);
    logic ok;
    ok = (k inside {3'd0, 3'd1, 3'd2, 3'd3, 3'd5});
    return pack(1'b0, 1'b0, ok ? k : 3'd0, ok && !(k == 3'd1 && !t), 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
  endfunction

  function automatic logic [7:0] exc_addr(input logic o, input logic v);
    if (o) return 8'd253;
    if (v) return 8'd254;
    return 8'd255;
  endfunction

  // Cycle i of an exception entry that waits mw cycles for memory (length mw+3).
  function automatic logic [OW-1:0] exc_cycle(input logic [7:0] va, input int i, input int mw);
    if (i == 0)       return pack(1'b0, 1'b1, 3'd0, 1'b0, 1'b1, va, 1'b1, 1'b0, 1'b0);
    if (i <= mw)      return pack(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, va, 1'b1, 1'b0, 1'b0);
    if (i == mw + 1)  return pack(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, va, 1'b0, 1'b1, 1'b0);
    return pack(1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
  endfunction

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cycle %0d: observed %05h expected %05h", tag, cyc, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Checks one cycle at the falling edge, advances the model, and retires
  // exception inputs whose acknowledge cycle just passed.
  task automatic cycle();
    logic [OW-1:0] e, e0;
    logic          ex;
    logic          clr_o, clr_v, clr_d, clr_o0;
    @(negedge clk);
    ex = exc_opcode | exc_ovf | exc_div0;
    e  = '0;
    e0 = '0;
    if (reset_n) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
      end else begin
        e = pack(!ex, 1'b0, 3'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        if (ex) begin
          for (int i = 0; i < MW + 3; i++)
            exp_q.push_back(exc_cycle(exc_addr(exc_opcode, exc_ovf), i, MW));
        end else if (req_valid) begin
          exp_q.push_back(issue_vec(req_kind, branch_taken));
        end
      end
      if (exp0_q.size() > 0) begin
        e0 = exp0_q.pop_front();
      end else begin
        e0 = pack(!exc_opcode0, 1'b0, 3'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        if (exc_opcode0) begin
          for (int i = 0; i < 3; i++) exp0_q.push_back(exc_cycle(8'd253, i, 0));
        end
      end
    end
    check("dut", pack(req_ready, exc_ack, pc_source, pc_write, epc_write, vec_addr,
                      vec_read, mdr_write, done), e);
    check("dut0", pack(req_ready0, exc_ack0, pc_source0, pc_write0, epc_write0, vec_addr0,
                       vec_read0, mdr_write0, done0), e0);
    clr_o  = e[16] && (e[10:3] == 8'd253);
    clr_v  = e[16] && (e[10:3] == 8'd254);
    clr_d  = e[16] && (e[10:3] == 8'd255);
    clr_o0 = e0[16];
    @(posedge clk);
    #1;
    cyc++;
    if (clr_o)  exc_opcode  = 1'b0;
    if (clr_v)  exc_ovf     = 1'b0;
    if (clr_d)  exc_div0    = 1'b0;
    if (clr_o0) exc_opcode0 = 1'b0;
  endtask

  task automatic request(input logic [2:0] k, input logic t);
    req_valid    = 1'b1;
    req_kind     = k;
    branch_taken = t;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n      = 1'b0;
    req_valid    = 1'b0;
    req_kind     = 3'd0;
    branch_taken = 1'b0;
    exc_opcode   = 1'b0;
    exc_ovf      = 1'b0;
    exc_div0     = 1'b0;
    exc_opcode0  = 1'b0;

    // Reset: everything low, including req_ready.
    cycle();
    cycle();
    reset_n = 1'b1;
    cycle();

    // Branch not taken, then taken.
    request(3'd1, 1'b0); cycle();
    req_valid = 1'b0;    cycle();
    request(3'd1, 1'b1); cycle();
    req_valid = 1'b0;    cycle();

    // Back-to-back jump then EPC return, request held through ISSUE.
    request(3'd2, 1'b0); cycle();
    request(3'd5, 1'b0); cycle();
    cycle();
    req_valid = 1'b0;    cycle();
    cycle();

    // Invalid kinds.
    request(3'd7, 1'b1); cycle();
    req_valid = 1'b0;    cycle();
    request(3'd4, 1'b1); cycle();
    request(3'd6, 1'b0); cycle();
    cycle();
    req_valid = 1'b0;    cycle();
    request(3'd0, 1'b0); cycle();
    req_valid = 1'b0;    cycle();
    request(3'd3, 1'b0); cycle();
    req_valid = 1'b0;    cycle();

    // Overflow and divide-by-zero together with a pending request.
    exc_ovf  = 1'b1;
    exc_div0 = 1'b1;
    request(3'd2, 1'b0);
    for (int i = 0; i < 14; i++) cycle();
    req_valid = 1'b0;
    cycle();

    // MEM_WAIT = 0 instance takes an invalid-opcode exception.
    exc_opcode0 = 1'b1;
    for (int i = 0; i < 5; i++) cycle();

    // Reset dropped mid-EXC_WAIT.
    exc_opcode = 1'b1;
    cycle();
    cycle();
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async", pack(req_ready, exc_ack, pc_source, pc_write, epc_write, vec_addr,
                            vec_read, mdr_write, done), '0);
    exp_q.delete();
    exp0_q.delete();
    cycle();
    reset_n = 1'b1;
    cycle();
    cycle();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      req_valid    = 1'($urandom_range(0, 1));
      req_kind     = 3'($urandom_range(0, 7));
      branch_taken = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 11) == 0) begin
        exc_opcode = exc_opcode | 1'($urandom_range(0, 1));
        exc_ovf    = exc_ovf    | 1'($urandom_range(0, 1));
        exc_div0   = exc_div0   | 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 19) == 0) exc_opcode0 = 1'b1;
      cycle();
    end

    // Drain outstanding work with a bounded budget.
    req_valid = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (exp_q.size() == 0 && exp0_q.size() == 0 &&
          !(exc_opcode | exc_ovf | exc_div0 | exc_opcode0)) break;
      cycle();
    end
    vectors++;
    assert (exp_q.size() == 0 && exp0_q.size() == 0) else begin
      miscompares++;
      $error("FAIL drain: observed %0d/%0d outstanding cycles expected 0/0",
             exp_q.size(), exp0_q.size());
    end
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
